// File: rtl/beacon_report_gen.sv
// Beacon report generator: forwards the 134-bit packet stream and splices
// periodic or requested 4-word report packets in at packet boundaries.
module beacon_report_gen #(
  parameter logic [7:0]  LMID       = 8'd11,
  parameter logic [31:0] PERIOD_CYC = 32'd125000,
  parameter logic [47:0] CTRL_MAC   = 48'h00_0C_00_00_00_01,
  parameter int unsigned FIFO_AW    = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [133:0] in_lr_data,
  input  logic         in_lr_data_wr,
  input  logic         in_lr_data_valid,
  input  logic         in_lr_data_valid_wr,
  input  logic [47:0]  in_local_mac_id,
  input  logic         in_report_req,
  output logic [133:0] out_lr_data,
  output logic         out_lr_data_wr,
  output logic         out_lr_data_valid,
  output logic         out_lr_data_valid_wr,
  output logic         out_fifo_overflow,
  output logic [31:0]  out_report_cnt
);

  localparam int unsigned DW    = 134;
  localparam int unsigned PW    = FIFO_AW + 1;
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [1:0]  HEAD  = 2'b01;
  localparam logic [1:0]  MID   = 2'b11;
  localparam logic [1:0]  TAIL  = 2'b10;

  typedef struct packed {
    logic          valid_wr;
    logic          valid;
    logic [DW-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE_S, PASS_S, RPT_S} state_e;

  state_e        state_q, state_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_wr_q, out_wr_d;
  logic          out_valid_q, out_valid_d;
  logic          out_valid_wr_q, out_valid_wr_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   rpt_cnt_q, rpt_cnt_d;
  logic [31:0]   ts_cnt_q, ts_cnt_d;
  logic [31:0]   rx_cnt_q, rx_cnt_d;
  logic [31:0]   ts_snap_q, ts_snap_d;
  logic [31:0]   rx_snap_q, rx_snap_d;
  logic [31:0]   period_q, period_d;
  logic          pend_q, pend_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  entry_t        fifo_mem [DEPTH];
  entry_t        top;
  entry_t        in_entry;
  logic [PW-1:0] fill;
  logic          full, empty, push, pop, emit_head, period_wrap;

  assign in_entry = '{valid_wr: in_lr_data_valid_wr, valid: in_lr_data_valid, data: in_lr_data};
  assign fill     = PW'(wr_ptr_q - rd_ptr_q);
  assign full     = (fill == PW'(DEPTH));
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign push     = in_lr_data_wr & ~full;
  assign top      = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];

  // Passthrough buffer storage; read side falls through combinationally.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= in_entry;
  end

  // Counters, pointers, sticky overflow and report-trigger coalescing.
  always_comb begin
    period_wrap = (period_q == PERIOD_CYC - 32'd1);
    period_d    = period_wrap ? 32'd0 : period_q + 32'd1;
    ts_cnt_d    = ts_cnt_q + 32'd1;
    rx_cnt_d    = rx_cnt_q + ((push && in_lr_data[133:132] == HEAD) ? 32'd1 : 32'd0);
    ovf_d       = ovf_q | (in_lr_data_wr & full);
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    pend_d      = (pend_q & ~emit_head) | period_wrap | in_report_req;
  end

  // Output sequencer: report priority at boundaries, passthrough, report emission.
  always_comb begin
    state_d        = state_q;
    wcnt_d         = wcnt_q;
    out_data_d     = '0;
    out_wr_d       = 1'b0;
    out_valid_d    = 1'b0;
    out_valid_wr_d = 1'b0;
    rpt_cnt_d      = rpt_cnt_q;
    ts_snap_d      = ts_snap_q;
    rx_snap_d      = rx_snap_q;
    pop            = 1'b0;
    emit_head      = 1'b0;
    case (state_q)
      IDLE_S: begin
        if (pend_q) begin
          out_wr_d   = 1'b1;
          out_data_d = {HEAD, 4'h0, CTRL_MAC, in_local_mac_id, 16'hFF01, 4'h0, 4'he, 8'h00};
          emit_head  = 1'b1;
          ts_snap_d  = ts_cnt_q;
          rx_snap_d  = rx_cnt_q;
          wcnt_d     = 2'd1;
          state_d    = RPT_S;
        end else if (!empty) begin
          pop = 1'b1;
          if (top.data[133:132] == HEAD) begin
            out_wr_d       = 1'b1;
            out_data_d     = top.data;
            out_valid_d    = top.valid;
            out_valid_wr_d = top.valid_wr;
            state_d        = PASS_S;
          end
        end
      end
      PASS_S: begin
        if (!empty) begin
          pop            = 1'b1;
          out_wr_d       = 1'b1;
          out_data_d     = top.data;
          out_valid_d    = top.valid;
          out_valid_wr_d = top.valid_wr;
          if (top.data[133:132] == TAIL) state_d = IDLE_S;
        end
      end
      RPT_S: begin
        out_wr_d = 1'b1;
        wcnt_d   = wcnt_q + 2'd1;
        case (wcnt_q)
          2'd1:    out_data_d = {MID, 4'h0, LMID, rpt_cnt_q, ts_snap_q, rx_snap_q, 24'h0};
          2'd2:    out_data_d = {MID, 132'h0};
          2'd3: begin
            out_data_d     = {TAIL, 132'h0};
            out_valid_d    = 1'b1;
            out_valid_wr_d = 1'b1;
            rpt_cnt_d      = rpt_cnt_q + 32'd1;
            state_d        = IDLE_S;
          end
          default: out_data_d = '0;
        endcase
      end
      default: state_d = IDLE_S;
    endcase
  end

  // State and output registers; reset abandons any partial packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE_S;
      wcnt_q         <= '0;
      out_data_q     <= '0;
      out_wr_q       <= 1'b0;
      out_valid_q    <= 1'b0;
      out_valid_wr_q <= 1'b0;
      ovf_q          <= 1'b0;
      rpt_cnt_q      <= '0;
      ts_cnt_q       <= '0;
      rx_cnt_q       <= '0;
      ts_snap_q      <= '0;
      rx_snap_q      <= '0;
      period_q       <= '0;
      pend_q         <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      out_data_q     <= out_data_d;
      out_wr_q       <= out_wr_d;
      out_valid_q    <= out_valid_d;
      out_valid_wr_q <= out_valid_wr_d;
      ovf_q          <= ovf_d;
      rpt_cnt_q      <= rpt_cnt_d;
      ts_cnt_q       <= ts_cnt_d;
      rx_cnt_q       <= rx_cnt_d;
      ts_snap_q      <= ts_snap_d;
      rx_snap_q      <= rx_snap_d;
      period_q       <= period_d;
      pend_q         <= pend_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
    end
  end

  assign out_lr_data          = out_data_q;
  assign out_lr_data_wr       = out_wr_q;
  assign out_lr_data_valid    = out_valid_q;
  assign out_lr_data_valid_wr = out_valid_wr_q;
  assign out_fifo_overflow    = ovf_q;
  assign out_report_cnt       = rpt_cnt_q;

endmodule
